md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
//  Multiply/divide unit in the E stage of the 5-stage MIPS pipeline; owns the HI/LO registers.
//  Runs MULT/MULTU/DIV/DIVU as multi-cycle operations, executes MTHI/MTLO and serves MFHI/MFLO.
//  Drives hilo_busy, which the hazard/stall unit consumes to hold md/mt/mf instructions in D.
// PARAMETERS
//  MULT_CYCLES  5   cycles busy is held after a MULT/MULTU start cycle (>=1)
//  DIV_CYCLES   10  cycles busy is held after a DIV/DIVU start cycle (>=1)
// PORTS
//  clk        in   1   single clock, rising edge
//  reset      in   1   asynchronous, active-high; clears all state
//  start      in   1   E-stage instr is MULT/MULTU/DIV/DIVU/MTHI/MTLO; qualifies md_op
//  md_op      in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO
//  A          in   32  rs operand (forwarded)
//  B          in   32  rt operand (forwarded)
//  busy       out  1   registered: multi-cycle op in flight
//  hilo_busy  out  1   start&(md_op<=3) | busy; goes to the stall unit as E_HILObusy
//  HI         out  32  current HI register
//  LO         out  32  current LO register
//  md_out     out  32  md_op==6 ? HI : md_op==7 ? LO : 0 (combinational, for MFHI/MFLO result)
// BEHAVIOUR
//  - Reset (async): state=IDLE, cnt=0, busy=0, HI=LO=0, pending regs=0; aborts any op in flight.
//  - FSM: IDLE -> MUL (start, op 0/1), IDLE -> DIV (start, op 2/3, B!=0); MUL/DIV -> IDLE at cnt==1.
//  - On start edge: compute result from A,B into pend_hi/pend_lo; load cnt=MULT_CYCLES or
//    DIV_CYCLES; busy=1. Each later edge cnt--; on edge with cnt==1: HI<=pend_hi, LO<=pend_lo,
//    busy<=0, cnt<=0. Start in cycle T: busy high T+1..T+N, new HI/LO visible from T+N+1.
//  - MULT: {HI,LO} = signed(A)*signed(B), 64-bit. MULTU: unsigned 64-bit product.
//  - DIV: LO = quotient truncated toward zero, HI = remainder with sign of dividend (signed).
//    DIVU: unsigned quotient/remainder. Overflow case 0x80000000 / -1 -> LO=0x80000000, HI=0.
//  - Divide by zero (B==0 on DIV/DIVU): no state change, busy stays 0, HI/LO unchanged.
//  - MTHI/MTLO: HI<=A / LO<=A on the start edge, one cycle, no busy.
//  - MFHI/MFLO: pure read, start may be 0; never changes state.
//  - start while busy: ignored (stall unit guarantees it cannot occur); verification asserts it.
//  - hilo_busy is high in the start cycle of a mult/div so a following md/mt/mf in D stalls
//    with zero bubble gap; hilo_busy low in the cycle after HI/LO commit.
//  - Widths: operands 32b; products/pending 64b; cnt width = $clog2(max(MULT,DIV)_CYCLES+1).
// STRUCTURE
//  - Shared package/header (md_defs): md_op encodings (MD_MULT..MD_MFLO), FSM state encodings.
//    The decoder in the control unit uses the same constants to generate md_op.
//  - Single module; arithmetic is combinational at start and latched; no sub-module needed.
//    A future iterative divider is a natural sub-module (md_divider) behind the same cnt timing.
// TESTING
//  - MULT A=0xFFFFFFFE(-2), B=3 -> busy 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
//  - MULTU A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE at cycle T+6; HI/LO unchanged T+1..T+5.
//  - DIV A=-7, B=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=7,B=2 -> LO=3,HI=1.
//  - DIV A=5, B=0 -> busy never rises, hilo_busy only in start cycle, HI/LO keep prior values.
//  - MTHI A=0x1234 then MFHI -> md_out=0x1234 next cycle; MTLO/MFLO likewise, busy stays 0.
//  - Reset asserted mid-DIV (cycle T+4) -> busy, HI, LO = 0 immediately; no later commit.

Source files
------------

// File: rtl/md_unit_pkg.sv
// ---------------------------------------------------------------------------
// md_unit_pkg
//   Shared definitions for the multiply/divide unit. The control-unit decoder
//   uses the same md_op encodings, so the two cannot drift apart.
//
//   Contents:
//     md_op_e     - md_op encodings (MD_MULT .. MD_MFLO)
//     md_state_e  - FSM state encodings for md_unit
//     md_mul()    - 32x32 -> 64 multiply, signed or unsigned
//     md_div()    - 32/32 divide returning {remainder, quotient}
// ---------------------------------------------------------------------------
package md_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_MFHI  = 3'd6,
    MD_MFLO  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

  // Full 64-bit product. The signed case sign-extends both operands to 64 bits
  // so a plain unsigned multiply of the extended values yields the correct
  // two's-complement result in the low 64 bits.
  function automatic logic [63:0] md_mul(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic        is_signed);
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    a_ext = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
    b_ext = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
    return a_ext * b_ext;
  endfunction

  // Returns {remainder, quotient}. Signed division is done on magnitudes and
  // the signs are fixed afterwards: quotient truncates toward zero, remainder
  // takes the sign of the dividend. This also covers 0x80000000 / -1 without
  // a special case: |a| = 0x80000000, q = 0x80000000, negation leaves it there,
  // and the remainder is 0.
  // A zero divisor returns 0; the caller never commits that result.
  function automatic logic [63:0] md_div(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic        is_signed);
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] q;
    logic [31:0] r;
    neg_a = is_signed & a[31];
    neg_b = is_signed & b[31];
    mag_a = neg_a ? (~a + 32'd1) : a;
    mag_b = neg_b ? (~b + 32'd1) : b;
    if (mag_b == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else begin
      q = mag_a / mag_b;
      r = mag_a % mag_b;
    end
    if (neg_a ^ neg_b) q = ~q + 32'd1;
    if (neg_a)         r = ~r + 32'd1;
    return {r, q};
  endfunction

endpackage

// File: rtl/md_unit.sv
// ---------------------------------------------------------------------------
// md_unit
//   Multiply/divide unit of the E stage; owns the HI/LO registers.
//   MULT/MULTU/DIV/DIVU compute their result combinationally on the start
//   edge, park it in pend_hi/pend_lo and commit it to HI/LO after a fixed
//   latency, so the architectural timing matches a multi-cycle datapath.
//   MTHI/MTLO write in one cycle; MFHI/MFLO are served through md_out.
//
// Parameters:
//   MULT_CYCLES  busy cycles after a MULT/MULTU start cycle (>=1)
//   DIV_CYCLES   busy cycles after a DIV/DIVU start cycle (>=1)
//
// Ports:
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous, active-high; clears all state
//   start      in   1   qualifies md_op for MULT/MULTU/DIV/DIVU/MTHI/MTLO
//   md_op      in   3   operation (see md_op_e)
//   A          in   32  rs operand
//   B          in   32  rt operand
//   busy       out  1   multi-cycle operation in flight (registered)
//   hilo_busy  out  1   stall request for the hazard unit
//   HI         out  32  HI register
//   LO         out  32  LO register
//   md_out     out  32  HI for MFHI, LO for MFLO, else 0
// ---------------------------------------------------------------------------
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        hilo_busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] md_out
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  md_op_e      op;
  md_state_e   state_q;
  md_state_e   state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;

  logic        load_mul;
  logic        load_div;
  logic        commit;
  logic        write_hi;
  logic        write_lo;
  logic [63:0] mul_res;
  logic [63:0] div_res;

  assign op = md_op_e'(md_op);

  // Both results are formed every cycle from the live operands; only the one
  // selected by load_mul/load_div is captured.
  assign mul_res = md_mul(A, B, op == MD_MULT);
  assign div_res = md_div(A, B, op == MD_DIV);

  // busy is a pure decode of the state register, so it carries no
  // combinational path from the inputs.
  assign busy      = (state_q != ST_IDLE);
  assign hilo_busy = (start & (md_op <= 3'd3)) | busy;

  // ------------------------------------------------------------------------
  // FSM state register
  // ------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // ------------------------------------------------------------------------
  // Next-state and control decode
  // ------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first; a path that left one
  // unassigned would infer a latch.
  always_comb begin
    state_d  = state_q;
    load_mul = 1'b0;
    load_div = 1'b0;
    commit   = 1'b0;
    write_hi = 1'b0;
    write_lo = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          unique case (op)
            MD_MULT, MD_MULTU: begin
              state_d  = ST_MUL;
              load_mul = 1'b1;
            end
            MD_DIV, MD_DIVU: begin
              // Divide by zero leaves the unit idle and HI/LO untouched.
              if (B != 32'd0) begin
                state_d  = ST_DIV;
                load_div = 1'b1;
              end
            end
            MD_MTHI: write_hi = 1'b1;
            MD_MTLO: write_lo = 1'b1;
            default: ;  // MFHI/MFLO never change state
          endcase
        end
      end

      // start is ignored here; the stall unit keeps md/mt/mf out of E while
      // hilo_busy is high.
      ST_MUL, ST_DIV: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          commit  = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------------------
  // Latency counter and pending result
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else if (load_mul) begin
      cnt_q              <= CNT_W'(MULT_CYCLES);
      {pend_hi, pend_lo} <= mul_res;
    end else if (load_div) begin
      cnt_q              <= CNT_W'(DIV_CYCLES);
      {pend_hi, pend_lo} <= div_res;
    end else if (state_q != ST_IDLE) begin
      // On the commit edge this takes cnt from 1 to 0.
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // ------------------------------------------------------------------------
  // Architectural HI/LO
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      HI <= '0;
      LO <= '0;
    end else if (commit) begin
      HI <= pend_hi;
      LO <= pend_lo;
    end else begin
      if (write_hi) HI <= A;
      if (write_lo) LO <= A;
    end
  end

  // ------------------------------------------------------------------------
  // MFHI/MFLO read path (combinational, independent of start)
  // ------------------------------------------------------------------------
  always_comb begin
    md_out = 32'd0;
    if (op == MD_MFHI)      md_out = HI;
    else if (op == MD_MFLO) md_out = LO;
  end

endmodule

// File: tb/tb_md_unit.sv
// ---------------------------------------------------------------------------
// tb_md_unit
//   Directed bench for md_unit. Stimulus pushes expected HI/LO pairs (for
//   mult/div commits) and expected md_out values (for MFHI/MFLO reads) into
//   queues; a negedge monitor pops and compares when the DUT presents them.
// ---------------------------------------------------------------------------
module tb_md_unit;
  import md_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        hilo_busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] md_out;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .md_op     (md_op),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .hilo_busy (hilo_busy),
    .HI        (HI),
    .LO        (LO),
    .md_out    (md_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] exp_hilo_q[$];   // {HI, LO} expected at each commit
  logic [31:0] exp_mf_q[$];     // md_out expected on each MF read
  logic        mf_req;
  logic [31:0] model_hi;
  logic [31:0] model_lo;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // The stall unit never lets a start reach a busy unit.
  always @(posedge clk)
    if (!reset) assert (!(start && busy)) else $error("start asserted while busy");

  // ------------------------------------------------------------------------
  // Monitor: a busy falling edge (outside reset) is a commit.
  // ------------------------------------------------------------------------
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    logic [63:0] e;
    logic [31:0] m;
    if (reset) begin
      prev_busy = 1'b0;
    end else begin
      if (prev_busy && !busy) begin
        if (exp_hilo_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_commit: HI=0x%0h LO=0x%0h, no commit expected", HI, LO);
        end else begin
          e = exp_hilo_q.pop_front();
          check("commit_HI", {32'd0, HI}, {32'd0, e[63:32]});
          check("commit_LO", {32'd0, LO}, {32'd0, e[31:0]});
        end
      end
      prev_busy = busy;
      if (mf_req) begin
        if (exp_mf_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_mf: md_out=0x%0h, no read expected", md_out);
        end else begin
          m = exp_mf_q.pop_front();
          check("md_out", {32'd0, md_out}, {32'd0, m});
        end
      end
    end
  end

  // ------------------------------------------------------------------------
  // Issue one MULT/MULTU/DIV/DIVU and track its busy window.
  // ------------------------------------------------------------------------
  task automatic do_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e_hi, input logic [31:0] e_lo, input int n_exp);
    int   n_busy;
    logic held;
    @(posedge clk); #1;
    start = 1'b1; md_op = op; A = a; B = b;
    exp_hilo_q.push_back({e_hi, e_lo});
    @(negedge clk);
    check("hilo_busy_start", {63'd0, hilo_busy}, 64'd1);
    check("busy_start",      {63'd0, busy},      64'd0);
    @(posedge clk); #1;
    start = 1'b0; md_op = MD_MFHI; A = 32'hdead_beef; B = 32'hcafe_f00d;
    n_busy = 0;
    held   = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      n_busy++;
      if (HI !== model_hi || LO !== model_lo) held = 1'b0;
    end
    check("busy_cycles",     64'(n_busy), 64'(n_exp));
    check("hilo_held",       {63'd0, held}, 64'd1);
    check("hilo_busy_after", {63'd0, hilo_busy}, 64'd0);
    model_hi = e_hi;
    model_lo = e_lo;
  endtask

  // One-cycle MTHI/MTLO followed by the matching MF read.
  task automatic do_mt_mf(input logic [2:0] mt, input logic [2:0] mf, input logic [31:0] a);
    @(posedge clk); #1;
    start = 1'b1; md_op = mt; A = a;
    @(negedge clk);
    check("mt_hilo_busy", {63'd0, hilo_busy}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0; md_op = mf; A = 32'd0;
    mf_req = 1'b1;
    exp_mf_q.push_back(a);
    @(negedge clk);
    check("mt_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    mf_req = 1'b0;
    if (mt == MD_MTHI) model_hi = a;
    else               model_lo = a;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected $finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic ok_busy;
    logic ok_hilo;
    reset = 1'b1; start = 1'b0; md_op = MD_MULT; A = 32'd0; B = 32'd0;
    mf_req = 1'b0; model_hi = 32'd0; model_lo = 32'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy",      {63'd0, busy},      64'd0);
    check("rst_hilo_busy", {63'd0, hilo_busy}, 64'd0);
    check("rst_HI",        {32'd0, HI},        64'd0);
    check("rst_LO",        {32'd0, LO},        64'd0);
    check("md_out_non_mf", {32'd0, md_out},    64'd0);

    do_md(MD_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    do_md(MD_MULTU, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, 5);
    do_md(MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5);
    do_md(MD_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    do_md(MD_DIVU,  32'd7,         32'd2,        32'h0000_0001, 32'h0000_0003, 10);
    do_md(MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10);
    do_md(MD_DIVU,  32'hFFFF_FFFF, 32'h10,       32'h0000_000F, 32'h0FFF_FFFF, 10);
    do_md(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10);

    // Put recognisable values in HI/LO before the divide-by-zero and reset tests.
    do_md(MD_MULTU, 32'h0001_0001, 32'h0001_0001, 32'h0000_0001, 32'h0002_0001, 5);

    // DIV by zero: hilo_busy only in the start cycle, nothing else moves.
    @(posedge clk); #1;
    start = 1'b1; md_op = MD_DIV; A = 32'd5; B = 32'd0;
    @(negedge clk);
    check("div0_hilo_busy_start", {63'd0, hilo_busy}, 64'd1);
    @(posedge clk); #1;
    start = 1'b0; md_op = MD_MFLO;
    ok_busy = 1'b1;
    ok_hilo = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (busy || hilo_busy) ok_busy = 1'b0;
      if (HI !== model_hi || LO !== model_lo) ok_hilo = 1'b0;
    end
    check("div0_no_busy", {63'd0, ok_busy}, 64'd1);
    check("div0_hilo",    {63'd0, ok_hilo}, 64'd1);

    do_mt_mf(MD_MTHI, MD_MFHI, 32'h0000_1234);
    do_mt_mf(MD_MTLO, MD_MFLO, 32'h0000_5678);
    // MFHI sees HI untouched by the MTLO.
    mf_req = 1'b1; md_op = MD_MFHI;
    exp_mf_q.push_back(32'h0000_1234);
    @(negedge clk);
    @(posedge clk); #1;
    mf_req = 1'b0;

    // Reset in cycle T+4 of a DIV: outputs clear at once, no commit later.
    @(posedge clk); #1;
    start = 1'b1; md_op = MD_DIVU; A = 32'd100; B = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; md_op = MD_MULT;
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_busy", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    #1;
    check("mid_reset_busy", {63'd0, busy}, 64'd0);
    check("mid_reset_HI",   {32'd0, HI},   64'd0);
    check("mid_reset_LO",   {32'd0, LO},   64'd0);
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    ok_busy = 1'b1;
    ok_hilo = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (busy) ok_busy = 1'b0;
      if (HI !== 32'd0 || LO !== 32'd0) ok_hilo = 1'b0;
    end
    check("post_reset_no_busy",   {63'd0, ok_busy}, 64'd1);
    check("post_reset_no_commit", {63'd0, ok_hilo}, 64'd1);

    repeat (2) @(negedge clk);
    check("commits_drained", 64'(exp_hilo_q.size()), 64'd0);
    check("reads_drained",   64'(exp_mf_q.size()),   64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
